// File: rtl/bayer2rgb_pkg.sv
// Shared definitions for the bayer2rgb pipeline: counter width default and
// the frame-tracking FSM encodings.
package bayer2rgb_pkg;

  localparam int CNT_W_DEF = 12;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_VSYNC = 2'd1;
  localparam logic [1:0] S_FRAME = 2'd2;

endpackage

// File: rtl/cmos_pix_counter_sync_edge_det.sv
// Single-bit polarity normaliser with a one-stage delay register and
// rise/fall pulses that compare the live level against the delayed one.
module sync_edge_det #(
  parameter bit POL = 1'b1
) (
  input  logic mclk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic dly_d;
  logic dly_q;

  always_comb begin
    lvl   = (din == POL);
    dly_d = lvl;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) dly_q <= 1'b0;
    else        dly_q <= dly_d;
  end

  assign rise = lvl & ~dly_q;
  assign fall = ~lvl & dly_q;

endmodule

// File: rtl/cmos_pix_counter.sv
// CMOS timing front end: per-line pixel count, line/frame counters, event
// pulses and a line-width lock flag. The partial frame after reset is skipped.
module cmos_pix_counter
  import bayer2rgb_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter bit VS_POL     = 1'b1,
  parameter bit HREF_POL   = 1'b1,
  parameter int LOCK_LINES = 4
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             cmos_vsync,
  input  logic             cmos_href,
  input  logic             pix_de,
  output logic [CNT_W-1:0] pixcnt,
  output logic [CNT_W-1:0] linecnt,
  output logic             line_end,
  output logic             frame_start,
  output logic             frame_done,
  output logic [CNT_W-1:0] line_width,
  output logic [CNT_W-1:0] frame_lines,
  output logic             locked
);

  localparam logic [3:0] LOCK_MAX = 4'(LOCK_LINES);

  logic vs_lvl, vs_rise, vs_fall;
  logic hr_lvl, hr_rise, hr_fall;

  sync_edge_det #(.POL(VS_POL)) u_vs_det (
    .mclk(mclk), .rst_n(rst_n), .din(cmos_vsync),
    .lvl(vs_lvl), .rise(vs_rise), .fall(vs_fall)
  );

  sync_edge_det #(.POL(HREF_POL)) u_hr_det (
    .mclk(mclk), .rst_n(rst_n), .din(cmos_href),
    .lvl(hr_lvl), .rise(hr_rise), .fall(hr_fall)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pixcnt_q, pixcnt_d;
  logic [CNT_W-1:0] linecnt_q, linecnt_d;
  logic [CNT_W-1:0] line_width_q, line_width_d;
  logic [CNT_W-1:0] frame_lines_q, frame_lines_d;
  logic [CNT_W-1:0] prev_w_q, prev_w_d;
  logic [3:0]       stable_q, stable_d;
  logic             line_end_q, line_end_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;
  logic             locked_q, locked_d;

  logic             pix_take;
  logic             line_close;
  logic [CNT_W-1:0] base_c;
  logic [CNT_W-1:0] width_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    pixcnt_d      = pixcnt_q;
    linecnt_d     = linecnt_q;
    line_width_d  = line_width_q;
    frame_lines_d = frame_lines_q;
    prev_w_d      = prev_w_q;
    stable_d      = stable_q;
    locked_d      = locked_q;
    line_end_d    = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;

    // A strobe on the href-fall cycle still belongs to the closing line.
    pix_take   = pix_de && (hr_lvl || hr_fall);
    base_c     = hr_rise ? '0 : pixcnt_q;
    width_c    = pix_take ? sat_inc(base_c) : base_c;
    line_close = hr_fall || (vs_rise && hr_lvl);

    case (state_q)
      S_IDLE: begin
        if (vs_lvl) state_d = S_VSYNC;
      end
      S_VSYNC: begin
        if (vs_fall) begin
          state_d       = S_FRAME;
          frame_start_d = 1'b1;
          linecnt_d     = '0;
          pixcnt_d      = '0;
        end
      end
      S_FRAME: begin
        pixcnt_d = width_c;
        if (line_close) begin
          line_end_d   = 1'b1;
          linecnt_d    = sat_inc(linecnt_q);
          line_width_d = width_c;
          pixcnt_d     = '0;
          if ((width_c == prev_w_q) && (width_c != '0)) begin
            if (stable_q != LOCK_MAX) stable_d = stable_q + 4'd1;
            if (stable_d == LOCK_MAX) locked_d = 1'b1;
          end else begin
            stable_d = '0;
            locked_d = 1'b0;
          end
          prev_w_d = width_c;
        end
        // The line close above is folded in before the frame snapshot.
        if (vs_rise) begin
          state_d       = S_VSYNC;
          frame_done_d  = 1'b1;
          frame_lines_d = linecnt_d;
          pixcnt_d      = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pixcnt_q      <= '0;
      linecnt_q     <= '0;
      line_width_q  <= '0;
      frame_lines_q <= '0;
      prev_w_q      <= '0;
      stable_q      <= '0;
      locked_q      <= 1'b0;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pixcnt_q      <= pixcnt_d;
      linecnt_q     <= linecnt_d;
      line_width_q  <= line_width_d;
      frame_lines_q <= frame_lines_d;
      prev_w_q      <= prev_w_d;
      stable_q      <= stable_d;
      locked_q      <= locked_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign pixcnt      = pixcnt_q;
  assign linecnt     = linecnt_q;
  assign line_end    = line_end_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign line_width  = line_width_q;
  assign frame_lines = frame_lines_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_cmos_pix_counter.sv
// Scoreboard bench for cmos_pix_counter: expected line/frame results are
// queued as stimulus is driven and popped when the DUT pulses line_end/frame_done.
module tb_cmos_pix_counter;

  localparam int CNT_W = 12;
  localparam int MAXV  = (1 << CNT_W) - 1;
  localparam int LOCK  = 4;

  logic             mclk = 1'b0;
  logic             rst_n;
  logic             cmos_vsync, cmos_href, pix_de;
  logic [CNT_W-1:0] pixcnt, linecnt, line_width, frame_lines;
  logic             line_end, frame_start, frame_done, locked;

  cmos_pix_counter #(
    .CNT_W(CNT_W), .VS_POL(1'b1), .HREF_POL(1'b1), .LOCK_LINES(LOCK)
  ) dut (
    .mclk(mclk), .rst_n(rst_n),
    .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .pix_de(pix_de),
    .pixcnt(pixcnt), .linecnt(linecnt),
    .line_end(line_end), .frame_start(frame_start), .frame_done(frame_done),
    .line_width(line_width), .frame_lines(frame_lines), .locked(locked)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int width;
    int lines;
    bit lock;
  } line_exp_t;

  line_exp_t line_q[$];
  int        frame_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int n_line_end_seen = 0;

  int exp_lines = 0;
  int exp_prev  = 0;
  int exp_run   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // Called at a negedge; returns at the next negedge with outputs updated.
  task automatic cycle(input logic v, input logic h, input logic d);
    cmos_vsync = v;
    cmos_href  = h;
    pix_de     = d;
    @(posedge mclk);
    @(negedge mclk);
  endtask

  task automatic frame_begin();
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("frame_start_pulse", frame_start, 1);
    exp_lines = 0;
    cycle(1'b0, 1'b0, 1'b0);
    check("frame_start_clear", frame_start, 0);
  endtask

  task automatic frame_end();
    frame_q.push_back(exp_lines);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
  endtask

  // Sends one href line of n pixels with random strobe gaps. coincident puts
  // the last pixel on the href-fall cycle; vs_at_end asserts vsync on that cycle.
  task automatic send_line(input int n, input bit coincident, input bit vs_at_end);
    line_exp_t e;
    int        sent;
    int        body;
    e.width   = sat(n);
    exp_lines = sat(exp_lines + 1);
    if ((e.width == exp_prev) && (e.width != 0)) begin
      if (exp_run < LOCK) exp_run++;
    end else begin
      exp_run = 0;
    end
    exp_prev = e.width;
    e.lines  = exp_lines;
    e.lock   = (exp_run == LOCK);
    line_q.push_back(e);
    if (vs_at_end) frame_q.push_back(exp_lines);

    body = coincident ? n - 1 : n;
    sent = 0;
    cycle(1'b0, 1'b1, 1'b0);
    while (sent < body) begin
      if ($urandom_range(0, 3) == 0) begin
        cycle(1'b0, 1'b1, 1'b0);
      end else begin
        cycle(1'b0, 1'b1, 1'b1);
        sent++;
        if (sent == 1 || sent == body) check("pixcnt_ramp", pixcnt, sat(sent));
      end
    end
    cycle(vs_at_end, 1'b0, coincident);
    check("pixcnt_after_close", pixcnt, 0);
    if (!vs_at_end) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    line_exp_t e;
    int        f;
    forever begin
      @(negedge mclk);
      if (line_end === 1'b1) begin
        n_line_end_seen++;
        if (line_q.size() == 0) begin
          check("unexpected_line_end", 1, 0);
        end else begin
          e = line_q.pop_front();
          check("line_width", line_width, e.width);
          check("linecnt", linecnt, e.lines);
          check("locked", locked, e.lock);
        end
      end
      if (frame_done === 1'b1) begin
        if (frame_q.size() == 0) begin
          check("unexpected_frame_done", 1, 0);
        end else begin
          f = frame_q.pop_front();
          check("frame_lines", frame_lines, f);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n      = 1'b0;
    cmos_vsync = 1'b0;
    cmos_href  = 1'b0;
    pix_de     = 1'b0;
    repeat (3) @(negedge mclk);
    check("rst_pixcnt", pixcnt, 0);
    check("rst_linecnt", linecnt, 0);
    check("rst_line_width", line_width, 0);
    check("rst_frame_lines", frame_lines, 0);
    check("rst_locked", locked, 0);
    check("rst_pulses", {line_end, frame_start, frame_done}, 0);
    #2 rst_n = 1'b1;
    @(negedge mclk);

    // Href activity before the first vsync is ignored.
    repeat (10) cycle(1'b0, 1'b1, 1'b1);
    check("idle_pixcnt", pixcnt, 0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("idle_no_line_end", n_line_end_seen, 0);

    // Basic frame: 3 lines of 640.
    frame_begin();
    repeat (3) send_line(640, 1'b0, 1'b0);
    frame_end();

    // Zero-width line breaks the run, then 5x640 locks and 639 unlocks.
    frame_begin();
    send_line(0, 1'b0, 1'b0);
    repeat (5) send_line(640, 1'b0, 1'b0);
    send_line(639, 1'b0, 1'b0);
    // Coincident pixel and href fall, then vsync on an href fall.
    send_line(100, 1'b1, 1'b0);
    send_line(20, 1'b0, 1'b1);

    // Saturation.
    frame_begin();
    send_line(5000, 1'b0, 1'b0);
    frame_end();

    // Lock, then reset mid-line.
    frame_begin();
    repeat (5) send_line(300, 1'b0, 1'b0);
    repeat (300) cycle(1'b0, 1'b1, 1'b1);
    check("pre_rst_pixcnt", pixcnt, 300);
    check("pre_rst_locked", locked, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pixcnt", pixcnt, 0);
    check("async_rst_locked", locked, 0);
    check("async_rst_linecnt", linecnt, 0);
    check("async_rst_line_width", line_width, 0);
    check("async_rst_frame_lines", frame_lines, 0);
    exp_prev = 0;
    exp_run  = 0;
    @(negedge mclk);
    cycle(1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    @(negedge mclk);

    // No counting until a full vsync pulse has been seen.
    cycle(1'b0, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, 1'b1, 1'b1);
    check("post_rst_pixcnt", pixcnt, 0);
    cycle(1'b0, 1'b0, 1'b0);
    frame_begin();
    repeat (2) send_line(50, 1'b0, 1'b0);
    frame_end();
    repeat (4) cycle(1'b1, 1'b0, 1'b0);

    check("line_q_drained", line_q.size(), 0);
    check("frame_q_drained", frame_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
